// File: rtl/exec_unit.sv
// exec_unit: execute stage with single-cycle ALU ops and an iterative shift-add 8x8 multiply.
// Define EXEC_MUL_EARLY_TERM_EN to end MUL as soon as the remaining multiplier bits are zero.
module exec_unit #(
    parameter int MUL_ITER = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [7:0] opA,
    input  logic [7:0] opB,
    input  logic [2:0] destNum,
    output logic       busy,
    output logic       writeEn,
    output logic [7:0] result,
    output logic [7:0] mulHighOut,
    output logic [2:0] regC_num,
    output logic       zeroFlag,
    output logic       carryFlag
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ALU  = 2'd1;
    localparam logic [1:0] MUL  = 2'd2;
    localparam logic [1:0] WB   = 2'd3;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic [1:0]  state;
    logic [2:0]  op_q, dest_q;
    logic [7:0]  a_q;
    logic [15:0] acc;
    logic [3:0]  cnt;
    logic [8:0]  alu_res, sum;
    logic [15:0] prod;
    logic        mul_done;

    // acc holds {high accumulator, multiplier}; its low byte doubles as operand B for ALU ops
    assign alu_res = op_q == 3'b000 ? {1'b0, a_q} + {1'b0, acc[7:0]}
                   : op_q == 3'b001 ? {1'b0, a_q} - {1'b0, acc[7:0]}
                   : op_q == 3'b010 ? {1'b0, a_q & acc[7:0]}
                   : op_q == 3'b011 ? {1'b0, a_q | acc[7:0]}
                   : op_q == 3'b100 ? {1'b0, a_q ^ acc[7:0]}
                   : op_q == 3'b101 ? {a_q, 1'b0}
                   : {a_q[0], 1'b0, a_q[7:1]};
    assign sum  = {1'b0, acc[15:8]} + (acc[0] ? {1'b0, a_q} : 9'd0);
    // skipped iterations only shift, so the final alignment is a single right shift
    assign prod = acc >> (4'(MUL_ITER) - cnt);
`ifdef EXEC_MUL_EARLY_TERM_EN
    assign mul_done = cnt != 4'd0 && (acc[7:0] & (8'hFF >> cnt)) == 8'd0;
`else
    assign mul_done = cnt == 4'(MUL_ITER);
`endif
    assign busy    = state != IDLE;
    assign writeEn = state == WB;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            result     <= '0;
            mulHighOut <= '0;
            regC_num   <= '0;
            zeroFlag   <= 1'b0;
            carryFlag  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_q   <= op;
                    a_q    <= opA;
                    acc    <= {8'd0, opB};
                    dest_q <= destNum;
                    cnt    <= '0;
                    state  <= op == OP_MUL ? MUL : ALU;
                end
                ALU: begin
                    result     <= alu_res[7:0];
                    mulHighOut <= 8'd0;
                    carryFlag  <= alu_res[8];
                    zeroFlag   <= alu_res[7:0] == 8'd0;
                    regC_num   <= dest_q;
                    state      <= WB;
                end
                MUL: if (mul_done) begin
                    result     <= prod[7:0];
                    mulHighOut <= prod[15:8];
                    carryFlag  <= |prod[15:8];
                    zeroFlag   <= prod[7:0] == 8'd0;
                    regC_num   <= dest_q;
                    state      <= WB;
                end else begin
                    acc <= {sum, acc[7:1]};
                    cnt <= cnt + 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed stimulus with a write-back scoreboard for exec_unit.
module tb_exec_unit;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [2:0] op = '0, destNum = '0;
    logic [7:0] opA = '0, opB = '0;
    logic       busy, writeEn, zeroFlag, carryFlag;
    logic [7:0] result, mulHighOut;
    logic [2:0] regC_num;
    int cyc = 0, n_cmp = 0, n_err = 0;

    typedef struct {
        int         cyc;
        logic [7:0] res;
        logic [7:0] hi;
        logic [2:0] num;
        logic       z;
        logic       c;
    } exp_t;
    exp_t q[$];

    exec_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opA(opA), .opB(opB),
        .destNum(destNum), .busy(busy), .writeEn(writeEn), .result(result),
        .mulHighOut(mulHighOut), .regC_num(regC_num), .zeroFlag(zeroFlag), .carryFlag(carryFlag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] res, output logic [7:0] hi, output logic c, output int delta);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        hi = 8'd0;
        c = 1'b0;
        delta = 1;
        case (o)
            3'd0: begin res = a + b; c = (int'(a) + int'(b)) > 255; end
            3'd1: begin res = a - b; c = a < b; end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: begin res = {a[6:0], 1'b0}; c = a[7]; end
            3'd6: begin res = {1'b0, a[7:1]}; c = a[0]; end
            default: begin
                res = p[7:0];
                hi = p[15:8];
                c = p[15:8] != 8'd0;
`ifdef EXEC_MUL_EARLY_TERM_EN
                delta = 2;
                for (int i = 0; i < 8; i++) if (b[i]) delta = i + 2;
`else
                delta = 9;
`endif
            end
        endcase
    endtask

    // Issue one op from a negedge; poke >= 0 pulses a conflicting start while busy
    task automatic op_exec(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] d, input int poke);
        exp_t e;
        int delta;
        model(o, a, b, e.res, e.hi, e.c, delta);
        e.z = e.res == 8'd0;
        e.num = d;
        e.cyc = cyc + 1 + delta;
        q.push_back(e);
        op = o; opA = a; opB = b; destNum = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i <= delta; i++) begin
            check("busy_high", busy, 1);
            if (i == poke) begin
                op = 3'd0; opA = 8'h11; opB = 8'h22; destNum = 3'd1; start = 1'b1;
            end else start = 1'b0;
            @(negedge clk);
        end
        check("busy_low", busy, 0);
        check("wb_missing", q.size(), 0);
    endtask

    task automatic check_zeroed();
        check("rst_busy", busy, 0);
        check("rst_we", writeEn, 0);
        check("rst_result", result, 0);
        check("rst_hi", mulHighOut, 0);
        check("rst_regc", regC_num, 0);
        check("rst_zero", zeroFlag, 0);
        check("rst_carry", carryFlag, 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (writeEn) begin
            if (q.size() == 0) check("spurious_wb", writeEn, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                check("wb_cycle", cyc, e.cyc);
                check("wb_result", result, e.res);
                check("wb_hi", mulHighOut, e.hi);
                check("wb_regc", regC_num, e.num);
                check("wb_zero", zeroFlag, e.z);
                check("wb_carry", carryFlag, e.c);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_zeroed();
        rst_n = 1'b1;
        @(negedge clk);
        op_exec(3'd0, 8'hF0, 8'h20, 3'd3, -1);
        op_exec(3'd1, 8'h05, 8'h05, 3'd2, -1);
        op_exec(3'd1, 8'h03, 8'h05, 3'd4, -1);
        op_exec(3'd2, 8'hC3, 8'h5A, 3'd5, -1);
        op_exec(3'd3, 8'hC3, 8'h5A, 3'd6, -1);
        op_exec(3'd4, 8'hFF, 8'hFF, 3'd0, -1);
        op_exec(3'd5, 8'h81, 8'h00, 3'd1, -1);
        op_exec(3'd6, 8'h01, 8'h00, 3'd2, -1);
        op_exec(3'd7, 8'hFF, 8'hFF, 3'd7, 2);
        op_exec(3'd7, 8'h0C, 8'h03, 3'd5, -1);
        op_exec(3'd7, 8'h9A, 8'h00, 3'd6, -1);
        op_exec(3'd7, 8'h03, 8'h80, 3'd1, -1);
        // abandon an in-flight multiply with a one-cycle reset
        op = 3'd7; opA = 8'hFF; opB = 8'hFF; destNum = 3'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_zeroed();
        repeat (12) @(negedge clk);
        check("abort_idle", busy, 0);
        op_exec(3'd0, 8'h01, 8'h01, 3'd2, -1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
